// File: rtl/axis_acc_pkg.sv
// Shared definitions for the AXI4-Stream frame accumulator:
// FSM state encoding, default accumulator width and the 32-bit clamp helper.
package axis_acc_pkg;

    localparam int ACC_W_DEFAULT = 40;

    typedef enum logic {
        S_ACCUM = 1'b0,
        S_EMIT  = 1'b1
    } state_t;

    // Clamp a wide unsigned value to 32 bits (all ones when it does not fit).
    function automatic logic [31:0] sat32(input logic [63:0] value);
        return (value[63:32] != 32'd0) ? 32'hFFFF_FFFF : value[31:0];
    endfunction

endpackage

// File: rtl/axis_acc_sat_adder.sv
// Combinational saturating accumulator adder: ACC_W-bit unsigned sum that
// sticks at all ones, plus the 32-bit clamped view and its saturation flag.
// ACC_W must be at least 33 and at most 64.
module axis_acc_sat_adder
    import axis_acc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [31:0]      data,
    output logic [ACC_W-1:0] sum,
    output logic [31:0]      clamp,
    output logic             sat
);

    logic [ACC_W:0] raw;

    // Add with one carry bit, pin to all ones on overflow, then clamp to 32 bits.
    always_comb begin
        raw   = {1'b0, acc} + {{(ACC_W - 31){1'b0}}, data};
        sum   = raw[ACC_W] ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
        clamp = sat32(64'(sum));
        sat   = (sum[ACC_W-1:32] != '0);
    end

endmodule

// File: rtl/axis_frame_accumulator.sv
// AXI4-Stream frame accumulator: sums every beat of a frame (terminated by
// tlast) and emits one saturated 32-bit beat with tlast=1. With the mode
// bit clear the stream passes straight through. The mode bit is sampled
// only at frame boundaries.
// Optional build macro AXIS_ACC_LEN_CHECK_EN: frames that reach
// MAX_FRAME_LEN beats without tlast are force-terminated and counted in
// len_err_count.
module axis_frame_accumulator
    import axis_acc_pkg::*;
#(
    parameter int ACC_W         = ACC_W_DEFAULT,
    parameter int MAX_FRAME_LEN = 256
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    input  logic        en,
    output logic [31:0] frame_count,
`ifdef AXIS_ACC_LEN_CHECK_EN
    output logic [31:0] len_err_count,
`endif
    output logic [31:0] sat_count
);

    localparam int CNT_W = (MAX_FRAME_LEN > 1) ? $clog2(MAX_FRAME_LEN) : 1;

    state_t             state;
    state_t             state_next;
    logic               mode;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   beat_cnt;
    logic [31:0]        result;
    logic               result_sat;

    logic [ACC_W-1:0]   acc_sum;
    logic [31:0]        acc_clamp;
    logic               acc_sat;

    logic               accum_beat;
    logic               emit_done;
    logic               frame_end;

    axis_acc_sat_adder #(
        .ACC_W (ACC_W)
    ) u_adder (
        .acc   (acc),
        .data  (s_axis_tdata),
        .sum   (acc_sum),
        .clamp (acc_clamp),
        .sat   (acc_sat)
    );

    // In accumulate mode S_ACCUM is always ready, so a valid beat is accepted.
    assign accum_beat = mode && (state == S_ACCUM) && s_axis_tvalid;
    assign emit_done  = mode && (state == S_EMIT) && m_axis_tready;

`ifdef AXIS_ACC_LEN_CHECK_EN
    assign frame_end = s_axis_tlast || (beat_cnt == CNT_W'(MAX_FRAME_LEN - 1));
`else
    assign frame_end = s_axis_tlast;
`endif

    // State register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= S_ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Next state: leave S_ACCUM on the closing beat, leave S_EMIT on handshake.
    always_comb begin
        state_next = state;
        case (state)
            S_ACCUM: if (accum_beat && frame_end) state_next = S_EMIT;
            S_EMIT:  if (emit_done)               state_next = S_ACCUM;
            default: state_next = S_ACCUM;
        endcase
    end

    // Stream outputs: pure passthrough in bypass, FSM-driven when accumulating.
    always_comb begin
        if (!mode) begin
            s_axis_tready = m_axis_tready;
            m_axis_tdata  = s_axis_tdata;
            m_axis_tvalid = s_axis_tvalid;
            m_axis_tlast  = s_axis_tlast;
        end else begin
            s_axis_tready = (state == S_ACCUM);
            m_axis_tdata  = result;
            m_axis_tvalid = (state == S_EMIT);
            m_axis_tlast  = (state == S_EMIT);
        end
    end

    // Datapath: mode latch, accumulator, beat counter, result and counters.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            mode        <= 1'b0;
            acc         <= '0;
            beat_cnt    <= '0;
            result      <= '0;
            result_sat  <= 1'b0;
            frame_count <= '0;
            sat_count   <= '0;
`ifdef AXIS_ACC_LEN_CHECK_EN
            len_err_count <= '0;
`endif
        end else begin
            if ((state == S_ACCUM) && (beat_cnt == '0)) begin
                mode <= en;
            end

            if (accum_beat) begin
                if (frame_end) begin
                    result     <= acc_clamp;
                    result_sat <= acc_sat;
                    acc        <= '0;
                    beat_cnt   <= '0;
`ifdef AXIS_ACC_LEN_CHECK_EN
                    if (!s_axis_tlast) begin
                        len_err_count <= len_err_count + 32'd1;
                    end
`endif
                end else begin
                    acc <= acc_sum;
                    // Saturating so a very long frame never looks like a boundary.
                    if (beat_cnt != '1) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
            end

            if (emit_done) begin
                frame_count <= frame_count + 32'd1;
                if (result_sat) begin
                    sat_count <= sat_count + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_frame_accumulator.sv
// Testbench for axis_frame_accumulator: directed frames; expected output
// beats are queued when stimulus is issued and a monitor pops them on each
// output handshake.
module tb_axis_frame_accumulator;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        en;
    logic [31:0] frame_count;
    logic [31:0] sat_count;
`ifdef AXIS_ACC_LEN_CHECK_EN
    logic [31:0] len_err_count;
`endif

    int total = 0;
    int bad   = 0;

    logic [32:0] exp_q[$];

    always #5 aclk = ~aclk;

    axis_frame_accumulator dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .en            (en),
        .frame_count   (frame_count),
`ifdef AXIS_ACC_LEN_CHECK_EN
        .len_err_count (len_err_count),
`endif
        .sat_count     (sat_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Monitor: every output handshake must match the head of the queue.
    always @(negedge aclk) begin
        if (!areset && m_axis_tvalid && m_axis_tready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL out_beat: got data=0x%08h last=%0b expected none", m_axis_tdata, m_axis_tlast);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                if ({m_axis_tlast, m_axis_tdata} !== e) begin
                    bad++;
                    $display("FAIL out_beat: got data=0x%08h last=%0b expected data=0x%08h last=%0b",
                             m_axis_tdata, m_axis_tlast, e[31:0], e[32]);
                end else begin
                    $display("ok   out_beat: data=0x%08h last=%0b", m_axis_tdata, m_axis_tlast);
                end
            end
        end
    end

    task automatic expect_beat(input logic [31:0] d, input logic l);
        exp_q.push_back({l, d});
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input logic [31:0] d, input logic l);
        bit accepted = 1'b0;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge aclk);
            if (s_axis_tready) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no s_tready expected accept of 0x%08h", d);
        end
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // Wait (bounded) until every queued expectation has been consumed.
    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge aclk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge aclk);
        #1;
    endtask

    initial begin
        areset        = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        en            = 1'b1;
        idle(3);
        chk("reset_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("reset_frame_count", frame_count, 32'd0);
        chk("reset_sat_count", sat_count, 32'd0);
        areset = 1'b0;
        idle(2);

        // 1: 3+5+7 = 15, valid one cycle after the last beat is accepted.
        expect_beat(32'd15, 1'b1);
        send(32'd3, 1'b0);
        send(32'd5, 1'b0);
        chk("t1_no_early_valid", 32'(m_axis_tvalid), 32'd0);
        send(32'd7, 1'b1);
        chk("t1_valid_latency", 32'(m_axis_tvalid), 32'd1);
        chk("t1_tlast", 32'(m_axis_tlast), 32'd1);
        drain();
        chk("t1_frame_count", frame_count, 32'd1);
        chk("t1_sat_count", sat_count, 32'd0);

        // 2: saturating sum.
        expect_beat(32'hFFFF_FFFF, 1'b1);
        send(32'hFFFF_FFFF, 1'b0);
        send(32'h0000_0002, 1'b1);
        drain();
        chk("t2_sat_count", sat_count, 32'd1);
        chk("t2_frame_count", frame_count, 32'd2);

        // 3: output stall holds data and back-pressures input.
        m_axis_tready = 1'b0;
        expect_beat(32'd42, 1'b1);
        send(32'd42, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk("t3_stall_tvalid", 32'(m_axis_tvalid), 32'd1);
            chk("t3_stall_tdata", m_axis_tdata, 32'd42);
            chk("t3_stall_s_tready", 32'(s_axis_tready), 32'd0);
        end
        @(posedge aclk);
        #1;
        m_axis_tready = 1'b1;
        drain();
        chk("t3_frame_count", frame_count, 32'd3);

        // 4: bypass.
        en = 1'b0;
        idle(2);
        m_axis_tready = 1'b0;
        @(negedge aclk);
        chk("t4_s_tready_low", 32'(s_axis_tready), 32'd0);
        @(posedge aclk);
        #1;
        m_axis_tready = 1'b1;
        @(negedge aclk);
        chk("t4_s_tready_high", 32'(s_axis_tready), 32'd1);
        @(posedge aclk);
        #1;
        expect_beat(32'd10, 1'b0);
        expect_beat(32'd20, 1'b1);
        send(32'd10, 1'b0);
        send(32'd20, 1'b1);
        drain();
        chk("t4_frame_count", frame_count, 32'd3);
        chk("t4_sat_count", sat_count, 32'd1);

        // 5: en drops mid-frame; current frame still summed, next passes through.
        en = 1'b1;
        idle(2);
        expect_beat(32'd3, 1'b1);
        send(32'd1, 1'b0);
        en = 1'b0;
        send(32'd2, 1'b1);
        drain();
        idle(2);
        expect_beat(32'd9, 1'b1);
        send(32'd9, 1'b1);
        drain();
        chk("t5_frame_count", frame_count, 32'd4);

        // 6: reset mid-frame discards the partial sum.
        en = 1'b1;
        idle(2);
        send(32'd4, 1'b0);
        areset = 1'b1;
        @(negedge aclk);
        chk("t6_reset_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("t6_reset_frame_count", frame_count, 32'd0);
        chk("t6_reset_sat_count", sat_count, 32'd0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        idle(2);
        expect_beat(32'd6, 1'b1);
        send(32'd6, 1'b1);
        drain();
        chk("t6_frame_count", frame_count, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
